// File: rtl/hilo_muldiv.sv
// HI/LO multiply/divide unit: single-cycle-latency 32x32 multiply, 32-step restoring divide,
// and mtlo/mthi register moves. Handshake: a request is taken when start=1 in IDLE; done pulses once results land.
module hilo_muldiv (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [4:0]  alu_control,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        busy,
  output logic        done,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  localparam logic [4:0] OP_MULT  = 5'b10000;
  localparam logic [4:0] OP_MULTU = 5'b10001;
  localparam logic [4:0] OP_DIV   = 5'b10010;
  localparam logic [4:0] OP_DIVU  = 5'b10011;
  localparam logic [4:0] OP_MTLO  = 5'b10101;
  localparam logic [4:0] OP_MTHI  = 5'b10110;

  typedef enum logic [1:0] {IDLE = 2'd0, MUL = 2'd1, DIV = 2'd2, FIX = 2'd3} state_t;

  state_t      state;
  state_t      state_next;
  logic [31:0] op_a;      // multiplicand, or dividend magnitude shifting into the quotient
  logic [31:0] op_b;      // multiplier, or divisor magnitude
  logic [31:0] rem;
  logic        op_signed;
  logic        neg_q;
  logic        neg_r;
  logic        div_zero;
  logic [5:0]  count;

  logic        accept;
  logic        is_mul;
  logic        is_div;
  logic        is_signed_op;
  logic [63:0] product;
  logic [32:0] trial;
  logic [32:0] diff;
  logic        qbit;
  logic [31:0] rem_next;

  assign accept       = start && (state == IDLE);
  assign is_mul       = (alu_control == OP_MULT) || (alu_control == OP_MULTU);
  assign is_div       = (alu_control == OP_DIV) || (alu_control == OP_DIVU);
  assign is_signed_op = (alu_control == OP_MULT) || (alu_control == OP_DIV);

  // 33-bit extended operands make one signed multiplier serve both mult and multu
  assign product = $signed({op_signed & op_a[31], op_a}) * $signed({op_signed & op_b[31], op_b});

  assign trial    = {rem, op_a[31]};
  assign diff     = trial - {1'b0, op_b};
  assign qbit     = ~diff[32];
  assign rem_next = qbit ? diff[31:0] : trial[31:0];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (accept && is_mul)      state_next = MUL;
        else if (accept && is_div) state_next = (B == 32'd0) ? FIX : DIV;
      end
      MUL:     state_next = IDLE;
      DIV:     state_next = (count == 6'd31) ? FIX : DIV;
      FIX:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    busy = (state != IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      HI        <= 32'd0;
      LO        <= 32'd0;
      done      <= 1'b0;
      op_a      <= 32'd0;
      op_b      <= 32'd0;
      rem       <= 32'd0;
      op_signed <= 1'b0;
      neg_q     <= 1'b0;
      neg_r     <= 1'b0;
      div_zero  <= 1'b0;
      count     <= 6'd0;
    end else begin
      done <= (state == MUL) || (state == FIX);
      case (state)
        IDLE: begin
          if (accept) begin
            if (alu_control == OP_MTLO) LO <= A;
            if (alu_control == OP_MTHI) HI <= A;
            if (is_mul) begin
              op_a      <= A;
              op_b      <= B;
              op_signed <= is_signed_op;
            end
            if (is_div) begin
              op_a     <= (is_signed_op && A[31]) ? -A : A;
              op_b     <= (is_signed_op && B[31]) ? -B : B;
              neg_q    <= is_signed_op && (A[31] ^ B[31]);
              neg_r    <= is_signed_op && A[31];
              div_zero <= (B == 32'd0);
              rem      <= 32'd0;
              count    <= 6'd0;
            end
          end
        end
        MUL: {HI, LO} <= product;
        DIV: begin
          op_a  <= {op_a[30:0], qbit};
          rem   <= rem_next;
          count <= count + 6'd1;
        end
        FIX: begin
          if (!div_zero) begin
            LO <= neg_q ? -op_a : op_a;
            HI <= neg_r ? -rem : rem;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_hilo_muldiv.sv
// Bench for hilo_muldiv: directed and random ops; expected {HI,LO} queued at issue and
// popped by a monitor whenever done pulses.
module tb_hilo_muldiv;

  localparam logic [4:0] OP_MULT  = 5'b10000;
  localparam logic [4:0] OP_MULTU = 5'b10001;
  localparam logic [4:0] OP_DIV   = 5'b10010;
  localparam logic [4:0] OP_DIVU  = 5'b10011;
  localparam logic [4:0] OP_MTLO  = 5'b10101;
  localparam logic [4:0] OP_MTHI  = 5'b10110;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [4:0]  alu_control;
  logic [31:0] A;
  logic [31:0] B;
  logic        busy;
  logic        done;
  logic [31:0] HI;
  logic [31:0] LO;

  int          checks = 0;
  int          errors = 0;
  logic [63:0] exp_q[$];
  logic [63:0] e_mon;
  logic [31:0] hi_m;
  logic [31:0] lo_m;

  hilo_muldiv dut (
    .clk(clk), .reset(reset), .start(start), .alu_control(alu_control),
    .A(A), .B(B), .busy(busy), .done(done), .HI(HI), .LO(LO)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h", name, act, exp);
    end
  endtask

  // reference: plain integer arithmetic on the architectural results
  function automatic logic [63:0] model(input logic [4:0] op, input logic [31:0] a,
                                        input logic [31:0] b, input logic [31:0] hi,
                                        input logic [31:0] lo);
    longint sa;
    longint sb;
    logic [63:0] r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    r  = {hi, lo};
    case (op)
      OP_MULT:  r = sa * sb;
      OP_MULTU: r = {32'd0, a} * {32'd0, b};
      OP_DIV:   if (b != 32'd0) r = {32'(sa % sb), 32'(sa / sb)};
      OP_DIVU:  if (b != 32'd0) r = {a % b, a / b};
      default:  r = {hi, lo};
    endcase
    return r;
  endfunction

  // monitor / scoreboard
  always @(negedge clk) begin
    if (!reset && done) begin
      chk("busy_with_done", {63'd0, busy}, 64'd0);
      if (exp_q.size() == 0) begin
        chk("unexpected_done", {63'd0, done}, 64'd0);
      end else begin
        e_mon = exp_q.pop_front();
        chk("hi", {32'd0, HI}, {32'd0, e_mon[63:32]});
        chk("lo", {32'd0, LO}, {32'd0, e_mon[31:0]});
      end
    end
  end

  // driver tasks
  task automatic scramble();
    start       = 1'b0;
    alu_control = 5'($urandom_range(31, 0));
    A           = $urandom;
    B           = $urandom;
  endtask

  task automatic issue(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    start = 1'b1; alu_control = op; A = a; B = b;
    @(posedge clk);
    #1;
    scramble();
  endtask

  task automatic wait_done(input int exp_lat);
    int n;
    n = 0;
    while (busy && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("latency", 64'(n), 64'(exp_lat));
    chk("done_after_busy", {63'd0, done}, 64'd1);
  endtask

  task automatic run_op_exp(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                            input logic [63:0] exp);
    int lat;
    if (op == OP_MTLO || op == OP_MTHI) begin
      issue(op, a, b);
      if (op == OP_MTLO) lo_m = a;
      else               hi_m = a;
      chk("mt_lo", {32'd0, LO}, {32'd0, lo_m});
      chk("mt_hi", {32'd0, HI}, {32'd0, hi_m});
      chk("mt_done", {63'd0, done}, 64'd0);
      chk("mt_busy", {63'd0, busy}, 64'd0);
    end else begin
      lat = ((op == OP_DIV || op == OP_DIVU) && b != 32'd0) ? 33 : 1;
      exp_q.push_back(exp);
      issue(op, a, b);
      wait_done(lat);
      {hi_m, lo_m} = exp;
    end
  endtask

  task automatic run_op(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    run_op_exp(op, a, b, model(op, a, b, hi_m, lo_m));
  endtask

  initial begin
    logic [4:0]  ops[6];
    logic [4:0]  bad_ops[4];
    logic [31:0] ra;
    logic [31:0] rb;
    logic [63:0] e;
    int          n;
    ops     = '{OP_MULT, OP_MULTU, OP_DIV, OP_DIVU, OP_MTLO, OP_MTHI};
    bad_ops = '{5'b00000, 5'b10100, 5'b10111, 5'b11111};

    reset = 1'b1;
    scramble();
    hi_m = 32'd0;
    lo_m = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_hi", {32'd0, HI}, 64'd0);
    chk("rst_lo", {32'd0, LO}, 64'd0);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_done", {63'd0, done}, 64'd0);
    @(negedge clk);
    reset = 1'b0;

    // directed vectors with known results
    run_op_exp(OP_MULT,  32'h86E1FB43, 32'h6B72C901, 64'hCD2A258D_D9FF9643);
    run_op_exp(OP_MULTU, 32'h86E1FB43, 32'h6B72C901, 64'h389CEE8E_D9FF9643);
    run_op_exp(OP_DIV,   32'h8396A10C, 32'h02A13C92, 64'hFF30BFDA_FFFFFFD1);
    run_op_exp(OP_DIVU,  32'h8396A10C, 32'h02A13C92, 64'h0018CC88_00000032);
    run_op(OP_MTLO, 32'h12345678, 32'd0);
    run_op(OP_MTHI, 32'h7B93A612, 32'd0);
    run_op_exp(OP_DIV,   32'h80000000, 32'hFFFFFFFF, 64'h00000000_80000000);

    // requests with codes outside the op set are dropped
    foreach (bad_ops[i]) begin
      issue(bad_ops[i], $urandom, $urandom);
      chk("bad_op_busy", {63'd0, busy}, 64'd0);
      chk("bad_op_hi", {32'd0, HI}, {32'd0, hi_m});
      chk("bad_op_lo", {32'd0, LO}, {32'd0, lo_m});
    end

    // mult issued five cycles into a divu is dropped, not queued
    ra = $urandom;
    rb = 32'($urandom_range(1000, 1));
    e  = model(OP_DIVU, ra, rb, hi_m, lo_m);
    exp_q.push_back(e);
    issue(OP_DIVU, ra, rb);
    n = 0;
    while (busy && n < 200) begin
      if (n == 4) begin
        @(negedge clk);
        start = 1'b1; alu_control = OP_MULT; A = $urandom; B = $urandom;
      end
      @(posedge clk);
      #1;
      start = 1'b0;
      n++;
    end
    chk("overlap_latency", 64'(n), 64'd33);
    chk("overlap_done", {63'd0, done}, 64'd1);
    {hi_m, lo_m} = e;
    repeat (3) @(posedge clk);
    #1;
    chk("mult_not_queued", {63'd0, busy}, 64'd0);

    // divide by zero leaves preloaded HI/LO untouched
    run_op(OP_MTHI, 32'hAAAAAAAA, 32'd0);
    run_op(OP_MTLO, 32'h55555555, 32'd0);
    run_op_exp(OP_DIV, $urandom, 32'd0, 64'hAAAAAAAA_55555555);
    run_op(OP_DIVU, $urandom, 32'd0);

    // random mix
    for (int k = 0; k < 40; k++) begin
      ra = $urandom;
      rb = $urandom;
      if ($urandom_range(7, 0) == 0) rb = 32'd0;
      if ($urandom_range(3, 0) == 0) rb = 32'($signed(16'($urandom)));
      run_op(ops[$urandom_range(5, 0)], ra, rb);
    end

    // reset in the middle of a division
    issue(OP_DIV, $urandom, 32'($urandom_range(9999, 1)));
    repeat (10) @(posedge clk);
    #2;
    chk("div_inflight", {63'd0, busy}, 64'd1);
    reset = 1'b1;
    #1;
    chk("abort_busy", {63'd0, busy}, 64'd0);
    chk("abort_hi", {32'd0, HI}, 64'd0);
    chk("abort_lo", {32'd0, LO}, 64'd0);
    chk("abort_done", {63'd0, done}, 64'd0);
    hi_m = 32'd0;
    lo_m = 32'd0;
    @(negedge clk);
    reset = 1'b0;
    run_op(OP_MULT, $urandom, $urandom);
    run_op(OP_MULTU, $urandom, $urandom);

    repeat (4) @(posedge clk);
    #1;
    chk("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/hilo_muldiv.md
HILO_MULDIV -- requirements
Module: hilo_muldiv

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock, all state updates on its rising edge.
REQ-002 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-003 SHALL have port start, input, 1 bit: operation request, sampled on each rising edge.
REQ-004 SHALL have port alu_control, input, 5 bits, with these op codes:
  - 10000 mult
  - 10001 multu
  - 10010 div
  - 10011 divu
  - 10101 mtlo
  - 10110 mthi
REQ-005 SHALL have port A, input, 32 bits: rs operand (multiplicand, dividend, mtlo/mthi source).
REQ-006 SHALL have port B, input, 32 bits: rt operand (multiplier, divisor).
REQ-007 SHALL have port busy, output, 1 bit: high while an operation is in flight; the core stalls mfhi/mflo and new mult/div while it is high.
REQ-008 SHALL have port done, output, 1 bit: one-cycle pulse when HI/LO hold a new mult/div result.
REQ-009 SHALL have port HI, output, 32 bits: HI register, drives ALU HI_input.
REQ-010 SHALL have port LO, output, 32 bits: LO register, drives ALU LO_input.

Function
REQ-011 SHALL implement a state machine with states IDLE, MUL, DIV and FIX; busy=0 only in IDLE.
REQ-012 SHALL accept a request only when start=1 and state=IDLE at a rising edge (the accept edge E0); start with busy=1 SHALL be ignored, with no queuing.
REQ-013 SHALL ignore start with an alu_control value outside the op set (no state change).
REQ-014 mtlo/mthi SHALL write A into LO/HI respectively at E0, stay in IDLE, leave the other register unchanged and not pulse done.
REQ-015 mult/multu timing:
  - E0 latches A and B, then IDLE->MUL.
  - E1 writes the 64-bit product {HI,LO}, then MUL->IDLE.
  - done=1 during the cycle after E1.
  - busy=1 for exactly one cycle.
REQ-016 mult SHALL form the product of sign-extended operands; multu SHALL form the product of zero-extended operands; the full 64-bit product is kept with no truncation.
REQ-017 div/divu at E0 SHALL latch the dividend and divisor magnitudes (absolute values for div, raw values for divu) plus the result signs, clear the 6-bit iteration counter, and go IDLE->DIV.
REQ-018 DIV SHALL perform restoring division, one quotient bit per cycle MSB first, for 32 cycles (E1..E32), then go to FIX.
REQ-019 FIX SHALL write the results at E33, then go to IDLE with done=1 during the following cycle; busy SHALL be high for 33 cycles.
  - LO = quotient: negated when the operand signs differ, for div only.
  - HI = remainder: negated when the dividend is negative, for div only.
REQ-020 Signed division SHALL truncate toward zero, with the remainder taking the dividend's sign.
REQ-021 div 0x80000000 / 0xFFFFFFFF SHALL give LO=0x80000000, HI=0x00000000, with no exception.
REQ-022 Divide by zero (B=0 at E0, div or divu) SHALL go to FIX and then IDLE: HI/LO unchanged, done pulses in the cycle after E1, busy high for 1 cycle.
REQ-023 HI and LO SHALL be unchanged except at the write edges defined above; during busy they SHALL hold their previous values.
REQ-024 Changes on A, B or alu_control after E0 SHALL NOT affect an in-flight operation.
REQ-025 done SHALL be registered, never asserted in the same cycle as busy=1, and start at the first post-done edge SHALL be accepted.

Reset
REQ-026 reset=1 SHALL asynchronously force state=IDLE, HI=0, LO=0, busy=0, done=0 and counter=0.
REQ-027 reset asserted mid-MUL/DIV/FIX SHALL abort the operation with no partial HI/LO write; the first edge after deassertion SHALL see IDLE.

Verification
REQ-028 Bench SHALL cover mult A=0x86E1FB43, B=0x6B72C901: done one cycle after E0, HI=0xCD2A258D, LO=0xD9FF9643; multu with the same operands gives HI=0x389CEE8E, LO=0xD9FF9643.
REQ-029 Bench SHALL cover div A=0x8396A10C, B=0x02A13C92: busy for 33 cycles, then LO=0xFFFFFFD1, HI=0xFF30BFDA; divu with the same operands gives LO=0x00000032, HI=0x0018CC88.
REQ-030 Bench SHALL cover mtlo A=0x12345678 then mthi A=0x7B93A612: LO=0x12345678 and HI=0x7B93A612 immediately after each edge, with done never asserted.
REQ-031 Bench SHALL cover a divu start followed by a mult start 5 cycles later: the mult is ignored and the divu result is written at E33.
REQ-032 Bench SHALL cover div with B=0 after mthi/mtlo preload 0xAAAAAAAA/0x55555555: HI/LO unchanged and done pulses after 1 busy cycle.
REQ-033 Bench SHALL cover reset asserted at DIV cycle 10: HI=LO=0 and busy=0 immediately, and a fresh mult completes normally afterwards.
